// File: rtl/fighter_anim_ctrl_if.sv
// Command and status bundle for one fighter's animation sequencer.
// The master drives the commands and pulses. The slave (the sequencer) drives the pose and status outputs.
interface fighter_anim_ctrl_if;
  logic        frame_tick;
  logic        restart;
  logic        cmd_walk;
  logic        cmd_punch;
  logic        cmd_jump;
  logic        hit_pulse;
  logic [31:0] offset_out;
  logic [2:0]  pose_idx;
  logic        attack_active;
  logic        busy;
  logic        ko;
  logic [3:0]  hit_count;

  modport master (
    output frame_tick, restart, cmd_walk, cmd_punch, cmd_jump, hit_pulse,
    input  offset_out, pose_idx, attack_active, busy, ko, hit_count
  );

  modport slave (
    input  frame_tick, restart, cmd_walk, cmd_punch, cmd_jump, hit_pulse,
    output offset_out, pose_idx, attack_active, busy, ko, hit_count
  );
endinterface

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation sequencer. It steps through eight poses on video-frame ticks,
// counts the hits taken, and produces the frame offset for the sprite ROM.
// Optional feature: define ANIM_INVULN_EN to discard hits that arrive while in JUMP or KICKED.
module fighter_anim_ctrl #(
  parameter logic [31:0] BASE_OFFSET = 32'h0,
  parameter int unsigned FRAME_WORDS = 50000,
  parameter int unsigned HOLD_TICKS  = 8,
  parameter int unsigned JUMP_TICKS  = 24,
  parameter int unsigned KICK_TICKS  = 16,
  parameter int unsigned HIT_LIMIT   = 5
) (
  input logic               Clk,
  input logic               Reset_n,
  fighter_anim_ctrl_if.slave anim
);

  // The encoding matches pose_idx, so the state register drives that output directly.
  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_WALK1  = 3'd1,
    ST_WALK2  = 3'd2,
    ST_FIST1  = 3'd3,
    ST_FIST2  = 3'd4,
    ST_DOWN   = 3'd5,
    ST_JUMP   = 3'd6,
    ST_KICKED = 3'd7
  } pose_e;

  localparam int unsigned MAX_HJ    = (HOLD_TICKS > JUMP_TICKS) ? HOLD_TICKS : JUMP_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_HJ > KICK_TICKS) ? MAX_HJ : KICK_TICKS;
  localparam int          TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] JUMP_LAST = TW'(JUMP_TICKS - 1);
  localparam logic [TW-1:0] KICK_LAST = TW'(KICK_TICKS - 1);
  localparam logic [3:0]    HIT_LIM   = 4'(HIT_LIMIT);

  pose_e         state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          hit_latch, latch_nxt;
  logic [3:0]    hit_count_q, count_nxt;
  logic          ko_q, ko_nxt;
  logic          hit_pend, hit_shielded;
  logic [31:0]   offset_q;
  logic          attack_q, busy_q;

  // The ROM offset of each pose is folded to a constant at elaboration.
  function automatic logic [31:0] pose_offset(input pose_e p);
    unique case (p)
      ST_STAND:  return 32'(BASE_OFFSET);
      ST_WALK1:  return 32'(BASE_OFFSET + 1 * FRAME_WORDS);
      ST_WALK2:  return 32'(BASE_OFFSET + 2 * FRAME_WORDS);
      ST_FIST1:  return 32'(BASE_OFFSET + 3 * FRAME_WORDS);
      ST_FIST2:  return 32'(BASE_OFFSET + 4 * FRAME_WORDS);
      ST_DOWN:   return 32'(BASE_OFFSET + 5 * FRAME_WORDS);
      ST_JUMP:   return 32'(BASE_OFFSET + 6 * FRAME_WORDS);
      default:   return 32'(BASE_OFFSET + 7 * FRAME_WORDS);
    endcase
  endfunction

  // Next-state logic: restart, then a pending hit, then the pose's own rules on a frame tick.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_nxt    = state;
    timer_nxt    = timer;
    count_nxt    = hit_count_q;
    ko_nxt       = ko_q;
    hit_pend     = hit_latch | anim.hit_pulse;
    latch_nxt    = hit_pend;
    hit_shielded = 1'b0;
`ifdef ANIM_INVULN_EN
    hit_shielded = (state == ST_JUMP) || (state == ST_KICKED);
`endif
    if (anim.restart) begin
      state_nxt = ST_STAND;
      timer_nxt = '0;
      latch_nxt = 1'b0;
      count_nxt = 4'd0;
      ko_nxt    = 1'b0;
    end else if (anim.frame_tick) begin
      // A tick always consumes the latched hit. This includes shielded hits and hits taken in DOWN.
      latch_nxt = 1'b0;
      if (state != ST_DOWN) begin
        if (hit_pend && !hit_shielded) begin
          count_nxt = hit_count_q + 4'd1;
          timer_nxt = '0;
          if (count_nxt == HIT_LIM) begin
            state_nxt = ST_DOWN;
            ko_nxt    = 1'b1;
          end else begin
            state_nxt = ST_KICKED;
          end
        end else begin
          unique case (state)
            ST_STAND, ST_WALK1, ST_WALK2: begin
              timer_nxt = '0;
              if (anim.cmd_jump)           state_nxt = ST_JUMP;
              else if (anim.cmd_punch)     state_nxt = ST_FIST1;
              else if (!anim.cmd_walk)     state_nxt = ST_STAND;
              else if (state == ST_STAND)  state_nxt = ST_WALK1;
              else if (timer == HOLD_LAST) state_nxt = (state == ST_WALK1) ? ST_WALK2 : ST_WALK1;
              else                         timer_nxt = timer + TW'(1);
            end
            ST_FIST1: begin
              if (timer == HOLD_LAST) begin
                state_nxt = ST_FIST2;
                timer_nxt = '0;
              end else timer_nxt = timer + TW'(1);
            end
            ST_FIST2: begin
              if (timer == HOLD_LAST) begin
                state_nxt = ST_STAND;
                timer_nxt = '0;
              end else timer_nxt = timer + TW'(1);
            end
            ST_JUMP: begin
              if (timer == JUMP_LAST) begin
                state_nxt = ST_STAND;
                timer_nxt = '0;
              end else timer_nxt = timer + TW'(1);
            end
            ST_KICKED: begin
              if (timer == KICK_LAST) begin
                state_nxt = ST_STAND;
                timer_nxt = '0;
              end else timer_nxt = timer + TW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // State and counter registers. Each output is registered from the next pose.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_STAND;
      timer       <= '0;
      hit_latch   <= 1'b0;
      hit_count_q <= 4'd0;
      ko_q        <= 1'b0;
      offset_q    <= BASE_OFFSET;
      attack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state       <= state_nxt;
      timer       <= timer_nxt;
      hit_latch   <= latch_nxt;
      hit_count_q <= count_nxt;
      ko_q        <= ko_nxt;
      offset_q    <= pose_offset(state_nxt);
      attack_q    <= (state_nxt == ST_FIST2);
      busy_q      <= (state_nxt == ST_FIST1) || (state_nxt == ST_FIST2) ||
                     (state_nxt == ST_JUMP)  || (state_nxt == ST_KICKED);
    end
  end

  assign anim.pose_idx      = state;
  assign anim.offset_out    = offset_q;
  assign anim.attack_active = attack_q;
  assign anim.busy          = busy_q;
  assign anim.ko            = ko_q;
  assign anim.hit_count     = hit_count_q;

endmodule
